// File: rtl/ps2_key_ctrl_if.sv
// Handshake between the keyboard scan-code FIFO (master) and the key sequencer (slave).
interface ps2_key_ctrl_if;
  logic       ready;
  logic [7:0] data;
  logic       overflow;
  logic       nextdata_n;

  modport master (output ready, output data, output overflow, input nextdata_n);
  modport slave  (input ready, input data, input overflow, output nextdata_n);
endinterface

// File: rtl/ps2_key_ctrl.sv
// Pops Set-2 scan codes from the keyboard FIFO, folds E0/F0 prefixes into press/break
// events, tracks the held key, counts presses and keeps a sticky FIFO-overflow flag.
module ps2_key_ctrl #(
  parameter int CNT_W      = 8,
  parameter int GAP_CYCLES = 1,
  parameter bit IGNORE_RPT = 1'b1
) (
  input  logic             clk,
  input  logic             clrn,
  ps2_key_ctrl_if.slave    kbd,
  input  logic             ovf_clr,
  output logic             key_valid,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_down,
  output logic [CNT_W-1:0] key_count,
  output logic             disp_en,
  output logic             ovf_sticky
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, POP, GAP} state_t;

  state_t          state_reg;
  logic [7:0]      byte_reg;
  logic            pend_ext_reg;
  logic            pend_brk_reg;
  logic [GW-1:0]   gap_cnt_reg;
  logic            same_key;

  assign same_key = (byte_reg == key_code) && (pend_ext_reg == key_ext);
  assign disp_en  = key_down;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_reg      <= IDLE;
      byte_reg       <= 8'h00;
      pend_ext_reg   <= 1'b0;
      pend_brk_reg   <= 1'b0;
      gap_cnt_reg    <= '0;
      kbd.nextdata_n <= 1'b1;
      key_valid      <= 1'b0;
      key_code       <= 8'h00;
      key_ext        <= 1'b0;
      key_down       <= 1'b0;
      key_count      <= '0;
      ovf_sticky     <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      unique case (state_reg)
        IDLE: begin
          if (kbd.ready) begin
            byte_reg       <= kbd.data;
            kbd.nextdata_n <= 1'b0;
            state_reg      <= POP;
          end
        end
        POP: begin
          kbd.nextdata_n <= 1'b1;
          gap_cnt_reg    <= '0;
          state_reg      <= GAP;
          if (byte_reg == 8'hE0) begin
            pend_ext_reg <= 1'b1;
          end else if (byte_reg == 8'hF0) begin
            pend_brk_reg <= 1'b1;
          end else begin
            pend_ext_reg <= 1'b0;
            pend_brk_reg <= 1'b0;
            if (pend_brk_reg) begin
              // A break only releases the key currently recorded as held.
              if (same_key) key_down <= 1'b0;
            end else if (!(key_down && same_key && IGNORE_RPT)) begin
              key_code  <= byte_reg;
              key_ext   <= pend_ext_reg;
              key_down  <= 1'b1;
              key_count <= key_count + CNT_W'(1);
              key_valid <= 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_cnt_reg == GAP_LAST) state_reg   <= IDLE;
          else                         gap_cnt_reg <= gap_cnt_reg + GW'(1);
        end
        default: state_reg <= IDLE;
      endcase

      // Overflow means bytes were lost: drop any half-built prefix so the stream resyncs.
      if (kbd.overflow) begin
        ovf_sticky   <= 1'b1;
        pend_ext_reg <= 1'b0;
        pend_brk_reg <= 1'b0;
      end else if (ovf_clr) begin
        ovf_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Directed bench for ps2_key_ctrl: a FIFO model feeds bytes, a scoreboard checks each press.
module tb_ps2_key_ctrl;
  logic clk = 1'b0;
  logic clrn = 1'b0;
  logic ovf_clr = 1'b0;
  always #5 clk = ~clk;

  ps2_key_ctrl_if ifa ();
  ps2_key_ctrl_if ifb ();
  assign ifb.ready    = ifa.ready;
  assign ifb.data     = ifa.data;
  assign ifb.overflow = ifa.overflow;

  logic       kv_a, ext_a, down_a, den_a, ovf_a;
  logic [7:0] code_a, cnt_a;
  logic       kv_b, ext_b, down_b, den_b, ovf_b;
  logic [7:0] code_b, cnt_b;

  ps2_key_ctrl #(.CNT_W(8), .GAP_CYCLES(1), .IGNORE_RPT(1'b1)) dut_a (
    .clk(clk), .clrn(clrn), .kbd(ifa.slave), .ovf_clr(ovf_clr),
    .key_valid(kv_a), .key_code(code_a), .key_ext(ext_a), .key_down(down_a),
    .key_count(cnt_a), .disp_en(den_a), .ovf_sticky(ovf_a));

  ps2_key_ctrl #(.CNT_W(8), .GAP_CYCLES(1), .IGNORE_RPT(1'b0)) dut_b (
    .clk(clk), .clrn(clrn), .kbd(ifb.slave), .ovf_clr(ovf_clr),
    .key_valid(kv_b), .key_code(code_b), .key_ext(ext_b), .key_down(down_b),
    .key_count(cnt_b), .disp_en(den_b), .ovf_sticky(ovf_b));

  int total = 0;
  int bad = 0;
  logic [7:0] fifo[$];
  logic [8:0] sb[$];
  int  cyc = 0;
  int  last_pop = -1;
  bit  spacing_chk = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // FIFO model: pops on the low strobe, presents its head away from the active edge.
  initial begin
    ifa.ready = 1'b0;
    ifa.data = 8'h00;
    ifa.overflow = 1'b0;
  end
  always @(negedge clk) begin
    if (ifa.nextdata_n === 1'b0 && fifo.size() > 0) void'(fifo.pop_front());
    ifa.ready = (fifo.size() > 0);
    ifa.data  = (fifo.size() > 0) ? fifo[0] : 8'h00;
  end

  // Scoreboard consumer and pop-spacing monitor.
  always @(negedge clk) begin
    logic [8:0] e;
    cyc++;
    if (kv_a === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_press", {23'd0, ext_a, code_a}, 32'h1ff);
      end else begin
        e = sb.pop_front();
        check("press_code", {23'd0, ext_a, code_a}, {23'd0, e});
        $display("press code=%02h ext=%0b count=%0d", code_a, ext_a, cnt_a);
      end
    end
    if (ifa.nextdata_n === 1'b0) begin
      if (spacing_chk && last_pop >= 0) check("pop_spacing", cyc - last_pop, 3);
      last_pop = cyc;
    end
  end

  task automatic push(input logic [7:0] b);
    fifo.push_back(b);
  endtask

  task automatic expect_press(input logic ext, input logic [7:0] code);
    sb.push_back({ext, code});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((fifo.size() > 0 || ifa.nextdata_n !== 1'b1) && n < 5000) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 5000) check("idle_timeout", 1, 0);
    repeat (4) @(negedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1 clrn = 1'b0;
    @(negedge clk); #1 clrn = 1'b1;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    check("rst_nextdata_n", ifa.nextdata_n, 1);
    check("rst_key_code", code_a, 0);
    check("rst_key_count", cnt_a, 0);
    check("rst_disp_en", den_a, 0);
    check("rst_ovf", ovf_a, 0);
    @(negedge clk); #1 clrn = 1'b1;

    // Single byte: exact pop strobe and N+2 latency.
    push(8'h1C); expect_press(1'b0, 8'h1C);
    n = 0;
    while (ifa.ready !== 1'b1 && n < 50) begin @(negedge clk); #1; n++; end
    check("ready_seen", ifa.ready, 1);
    @(negedge clk); #1;
    check("pop_low_n1", ifa.nextdata_n, 0);
    @(negedge clk); #1;
    check("kv_n2", kv_a, 1);
    check("code_n2", code_a, 8'h1C);
    check("down_n2", down_a, 1);
    check("count_n2", cnt_a, 1);
    check("pop_high_n2", ifa.nextdata_n, 1);
    @(negedge clk); #1;
    check("kv_n3", kv_a, 0);
    wait_idle();

    // Reset while a pop is in flight, with a pending F0 prefix.
    push(8'hF0); wait_idle();
    push(8'h22);
    n = 0;
    while (ifa.nextdata_n !== 1'b0 && n < 50) begin @(negedge clk); #1; n++; end
    check("pop_seen", ifa.nextdata_n, 0);
    clrn = 1'b0; #1;
    check("async_nextdata_n", ifa.nextdata_n, 1);
    check("async_key_down", down_a, 0);
    check("async_key_code", code_a, 0);
    check("async_key_count", cnt_a, 0);
    @(negedge clk); @(negedge clk); #1 clrn = 1'b1;
    push(8'h1C); expect_press(1'b0, 8'h1C); wait_idle();
    check("post_rst_count", cnt_a, 1);
    check("post_rst_down", down_a, 1);

    // Typematic repeats then break.
    push(8'h1C); push(8'h1C); wait_idle();
    check("rpt_count", cnt_a, 1);
    check("rpt_count_norpt", cnt_b, 3);
    push(8'hF0); push(8'h1C); wait_idle();
    check("brk_down", down_a, 0);
    check("brk_disp_en", den_a, 0);
    check("brk_down_norpt", down_b, 0);

    // Extended key press/release; non-extended break must not release it.
    push(8'hE0); push(8'h75); expect_press(1'b1, 8'h75); wait_idle();
    check("ext_code", code_a, 8'h75);
    check("ext_flag", ext_a, 1);
    check("ext_down", down_a, 1);
    push(8'hE0); push(8'hF0); push(8'h75); wait_idle();
    check("ext_release", down_a, 0);
    push(8'hE0); push(8'h75); expect_press(1'b1, 8'h75); wait_idle();
    push(8'hF0); push(8'h75); wait_idle();
    check("ext_plain_brk_ignored", down_a, 1);
    check("ext_count", cnt_a, 3);

    // Counter wrap with ready held high.
    pulse_reset();
    for (int i = 0; i < 256; i++) begin
      push((i % 2 == 0) ? 8'h1C : 8'h32);
      expect_press(1'b0, (i % 2 == 0) ? 8'h1C : 8'h32);
    end
    last_pop = -1;
    spacing_chk = 1;
    wait_idle();
    spacing_chk = 0;
    check("wrap_count", cnt_a, 0);
    check("wrap_code", code_a, 8'h32);
    check("wrap_count_norpt", cnt_b, 0);

    // Sticky overflow priority and prefix resync.
    ifa.overflow = 1'b1; ovf_clr = 1'b1;
    @(negedge clk); #1;
    check("ovf_set_wins", ovf_a, 1);
    ifa.overflow = 1'b0;
    @(negedge clk); #1;
    check("ovf_cleared", ovf_a, 0);
    ovf_clr = 1'b0;
    push(8'hF0); wait_idle();
    ifa.overflow = 1'b1;
    @(negedge clk); #1 ifa.overflow = 1'b0;
    push(8'h1C); expect_press(1'b0, 8'h1C); wait_idle();
    check("resync_count", cnt_a, 1);
    check("resync_code", code_a, 8'h1C);
    check("resync_ovf", ovf_a, 1);

    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
